hex_display_arbiter: RTL and testbench
======================================

HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000, SHALL set the minimum number of clk cycles one requester owns the display; legal range 1..2^26-1.
REQ-002 Parameter CNT_W, default 26, SHALL be the hold-counter width.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  per-requester level request, bit i = requester i.
REQ-006 data0, data1, data2  input  16  per-requester value to display (four hex nibbles).
REQ-007 ack  output  3  one-cycle grant pulse, one-hot or zero.
REQ-008 disp_data  output  16  value driven to the 4-digit hex display driver.
REQ-009 disp_valid  output  1  high while a requester owns the display.
REQ-010 owner  output  2  index of current/last owner (0..2).

Function
REQ-011 The block SHALL use two states: IDLE and SHOW, held in registers.
REQ-012 Arbitration SHALL be round-robin: search order starts at (owner+1) mod 3 and wraps; the current owner has lowest priority.
REQ-013 In IDLE, if any req bit is high at a rising edge, that edge SHALL: select winner w per REQ-012, set owner=w, load disp_data=data_w, set disp_valid=1, load hold counter with HOLD_CYCLES-1, enter SHOW, and assert ack[w] for exactly the following cycle.
REQ-014 In IDLE with req==0, all registers SHALL hold; disp_data SHALL keep the last displayed value; disp_valid=0.
REQ-015 In SHOW, while req[owner]=1, disp_data SHALL be updated each edge with data_owner (live tracking, one-cycle latency).
REQ-016 In SHOW, if req[owner] drops, disp_data SHALL freeze at its last value and the hold SHALL still run to completion (no early release).
REQ-017 In SHOW, the hold counter SHALL decrement by 1 per edge while nonzero; no preemption by any requester.
REQ-018 At the edge where the counter is 0 in SHOW: if any req is high, the block SHALL re-arbitrate per REQ-012/REQ-013 in that same edge (stay SHOW, no idle gap, ack pulse for new winner); otherwise it SHALL enter IDLE with disp_valid=0.
REQ-019 Re-arbitration at REQ-018 MAY re-grant the same owner only if no other req bit is high; ack SHALL pulse again in that case.
REQ-020 HOLD_CYCLES=1 SHALL yield each SHOW ownership lasting exactly one cycle.
REQ-021 ack SHALL never have more than one bit set and SHALL be 0 in every cycle without a grant.
REQ-022 Counter arithmetic SHALL be unsigned CNT_W bits and SHALL never wrap below 0.
REQ-023 Changes on data inputs of non-owners SHALL never affect disp_data.

Reset
REQ-024 While rst_n=0, asynchronously: state=IDLE, disp_data=16'h0000, disp_valid=0, ack=3'b000, counter=0, owner=2 (so requester 0 has top priority after reset).
REQ-025 Assertion of rst_n mid-SHOW SHALL abort ownership immediately with no ack or further update; first grant SHALL occur on the first rising edge after rst_n deasserts with req nonzero.

Verification (bench uses HOLD_CYCLES=4)
REQ-026 Reset release, req=3'b111, data0=16'h1234 -> next cycle ack=3'b001, owner=0, disp_data=16'h1234, disp_valid=1.
REQ-027 req=3'b111 held continuously -> owners granted 0,1,2,0,... each exactly 4 cycles, ack pulse at every switch, no idle gap.
REQ-028 Single req[1]=1, data1 stepping 16'h0001, 0002, 0003 each cycle -> disp_data follows with one-cycle latency; after req[1] drops, disp_data frozen, disp_valid stays 1 until 4 cycles elapse, then 0.
REQ-029 Only req[2] held after its hold ends -> re-granted to 2 with new ack[2] pulse; owner stays 2.
REQ-030 rst_n pulsed low during cycle 2 of a SHOW -> outputs immediately at REQ-024 values; after release with req=3'b010, ack=3'b010 one cycle later.
REQ-031 Grant-time boundary: req[0] rises exactly on the counter-zero edge while owner=0 and req[1]=1 -> grant goes to 1, not 0.

Source files
------------

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter that hands a shared 4-digit hex display to one of three
// requesters for a minimum hold time, then re-arbitrates without an idle gap.
module hex_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 32'd50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  ack,
  output logic [15:0] disp_data,
  output logic        disp_valid,
  output logic [1:0]  owner
);

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 32'd1);

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_owner, w_owner_next;
  logic [15:0]      r_disp_data, w_disp_data_next;
  logic             r_disp_valid, w_disp_valid_next;
  logic [2:0]       r_ack, w_ack_next;

  logic             w_any;
  logic             w_grant;
  logic [1:0]       w_win;
  logic [15:0]      w_win_data;
  logic [15:0]      w_own_data;
  logic             w_own_req;

  // Round-robin winner: search starts just after the current owner, which ranks last.
  always_comb begin
    w_any = |req;
    w_win = 2'd0;
    case (r_owner)
      2'd0: begin
        if (req[1])      w_win = 2'd1;
        else if (req[2]) w_win = 2'd2;
        else             w_win = 2'd0;
      end
      2'd1: begin
        if (req[2])      w_win = 2'd2;
        else if (req[0]) w_win = 2'd0;
        else             w_win = 2'd1;
      end
      default: begin
        if (req[0])      w_win = 2'd0;
        else if (req[1]) w_win = 2'd1;
        else             w_win = 2'd2;
      end
    endcase
  end

  // Data muxes for the prospective winner and for the current owner.
  always_comb begin
    w_win_data = data0;
    case (w_win)
      2'd1:    w_win_data = data1;
      2'd2:    w_win_data = data2;
      default: w_win_data = data0;
    endcase
    w_own_data = data0;
    w_own_req  = req[0];
    case (r_owner)
      2'd1: begin
        w_own_data = data1;
        w_own_req  = req[1];
      end
      2'd2: begin
        w_own_data = data2;
        w_own_req  = req[2];
      end
      default: begin
        w_own_data = data0;
        w_own_req  = req[0];
      end
    endcase
  end

  // Next-state and output logic: grant from IDLE or at hold expiry, otherwise count down.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_owner_next      = r_owner;
    w_disp_data_next  = r_disp_data;
    w_disp_valid_next = r_disp_valid;
    w_ack_next        = 3'b000;
    w_grant           = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_any) w_grant = 1'b1;
        else       w_disp_valid_next = 1'b0;
      end
      StShow: begin
        if (r_cnt != '0) begin
          // No preemption while the hold runs; a dropped request only freezes the value.
          w_cnt_next = r_cnt - 1'b1;
          if (w_own_req) w_disp_data_next = w_own_data;
        end else if (w_any) begin
          w_grant = 1'b1;
        end else begin
          w_state_next      = StIdle;
          w_disp_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next      = StIdle;
        w_disp_valid_next = 1'b0;
      end
    endcase

    if (w_grant) begin
      w_state_next      = StShow;
      w_owner_next      = w_win;
      w_disp_data_next  = w_win_data;
      w_disp_valid_next = 1'b1;
      w_cnt_next        = HoldLoad;
      w_ack_next        = 3'b001 << w_win;
    end
  end

  // State registers; owner resets to 2 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_owner      <= 2'd2;
      r_disp_data  <= 16'h0000;
      r_disp_valid <= 1'b0;
      r_ack        <= 3'b000;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_owner      <= w_owner_next;
      r_disp_data  <= w_disp_data_next;
      r_disp_valid <= w_disp_valid_next;
      r_ack        <= w_ack_next;
    end
  end

  assign ack        = r_ack;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;
  assign owner      = r_owner;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter with a cycle-level ownership model.
module tb_hex_display_arbiter;

  localparam int unsigned Hold = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [15:0] d0 = 16'h0, d1 = 16'h0, d2 = 16'h0;
  logic [2:0]  ack;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic [1:0]  owner;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: who owns the display and for how many cycles so far.
  logic [1:0]  m_owner;
  logic        m_valid;
  logic [15:0] m_disp;
  logic [2:0]  m_ack;
  int          m_elapsed;

  hex_display_arbiter #(
    .HOLD_CYCLES(Hold),
    .CNT_W      (26)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data0     (d0),
    .data1     (d1),
    .data2     (d2),
    .ack       (ack),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pick(input int i);
    if (i == 0) return d0;
    if (i == 1) return d1;
    return d2;
  endfunction

  // Next in the circular order after the owner that is requesting; owner itself last.
  function automatic logic [1:0] rr(input logic [1:0] own, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (int'(own) + k) % 3;
      if (r[i]) return 2'(i);
    end
    return own;
  endfunction

  task automatic model_reset();
    m_owner = 2'd2; m_valid = 1'b0; m_disp = 16'h0; m_ack = 3'b000; m_elapsed = 0;
  endtask

  // Advance one clock and move the model by the inputs seen at that edge.
  task automatic step();
    @(posedge clk);
    m_ack = 3'b000;
    if (!m_valid || m_elapsed >= int'(Hold)) begin
      if (req != 3'b000) begin
        m_owner   = rr(m_owner, req);
        m_disp    = pick(int'(m_owner));
        m_valid   = 1'b1;
        m_elapsed = 1;
        m_ack     = 3'b001 << m_owner;
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_elapsed++;
      if (req[m_owner]) m_disp = pick(int'(m_owner));
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = 3'b000;
    model_reset();
    #1;
    n_chk++;
    if ({ack, disp_valid, owner, disp_data} !== {3'b000, 1'b0, 2'd2, 16'h0000})
      $display("FAIL reset_values: got ack=%b valid=%b owner=%0d data=%h", ack, disp_valid,
               owner, disp_data);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_chk++;
    if ({ack, disp_valid, owner, disp_data} !== {3'b000, 1'b0, 2'd2, 16'h0000})
      $display("FAIL reset_idle_hold: got ack=%b valid=%b owner=%0d data=%h", ack, disp_valid,
               owner, disp_data);
    else n_pass++;
  endtask

  task automatic test_first_grant();
    do_reset();
    req = 3'b111; d0 = 16'h1234; d1 = 16'h5555; d2 = 16'h6666;
    step();
    n_chk++;
    if ({ack, disp_valid, owner, disp_data} !== {3'b001, 1'b1, 2'd0, 16'h1234})
      $display("FAIL first_grant: got ack=%b valid=%b owner=%0d data=%h want 001/1/0/1234",
               ack, disp_valid, owner, disp_data);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_own;
    logic [2:0] exp_ack;
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 24; i++) begin
      d0 = 16'h0A00 + 16'(i); d1 = 16'h0B00 + 16'(i); d2 = 16'h0C00 + 16'(i);
      step();
      exp_own = 2'((i / int'(Hold)) % 3);
      exp_ack = (i % int'(Hold) == 0) ? (3'b001 << exp_own) : 3'b000;
      n_chk++;
      if ({ack, disp_valid, owner, disp_data} !== {exp_ack, 1'b1, exp_own, m_disp})
        $display("FAIL round_robin[%0d]: got ack=%b valid=%b owner=%0d data=%h want %b/1/%0d/%h",
                 i, ack, disp_valid, owner, disp_data, exp_ack, exp_own, m_disp);
      else n_pass++;
    end
  endtask

  task automatic test_tracking();
    do_reset();
    req = 3'b010; d0 = 16'hDEAD; d2 = 16'hBEEF;
    for (int i = 1; i <= 3; i++) begin
      d1 = 16'(i);
      step();
      n_chk++;
      if ({disp_valid, owner, disp_data} !== {1'b1, 2'd1, 16'(i)})
        $display("FAIL track[%0d]: got valid=%b owner=%0d data=%h want 1/1/%h", i, disp_valid,
                 owner, disp_data, 16'(i));
      else n_pass++;
    end
    req = 3'b000; d1 = 16'h0009;
    step();
    n_chk++;
    if ({disp_valid, disp_data} !== {1'b1, 16'h0003})
      $display("FAIL track_freeze: got valid=%b data=%h want 1/0003", disp_valid, disp_data);
    else n_pass++;
    step();
    n_chk++;
    if ({ack, disp_valid, disp_data} !== {3'b000, 1'b0, 16'h0003})
      $display("FAIL track_release: got ack=%b valid=%b data=%h want 000/0/0003", ack,
               disp_valid, disp_data);
    else n_pass++;
  endtask

  task automatic test_regrant_same();
    do_reset();
    req = 3'b100; d2 = 16'h2222;
    for (int i = 0; i < 9; i++) begin
      step();
      n_chk++;
      if ({ack, disp_valid, owner} !== {((i % int'(Hold)) == 0) ? 3'b100 : 3'b000, 1'b1, 2'd2})
        $display("FAIL regrant_same[%0d]: got ack=%b valid=%b owner=%0d", i, ack, disp_valid,
                 owner);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    req = 3'b111; d0 = 16'h7777;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ack, disp_valid, owner, disp_data} !== {3'b000, 1'b0, 2'd2, 16'h0000})
      $display("FAIL mid_show_reset: got ack=%b valid=%b owner=%0d data=%h", ack, disp_valid,
               owner, disp_data);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    req = 3'b010; d1 = 16'h4321;
    model_reset();
    step();
    n_chk++;
    if ({ack, disp_valid, owner, disp_data} !== {3'b010, 1'b1, 2'd1, 16'h4321})
      $display("FAIL post_reset_grant: got ack=%b valid=%b owner=%0d data=%h", ack, disp_valid,
               owner, disp_data);
    else n_pass++;
  endtask

  task automatic test_boundary();
    do_reset();
    req = 3'b001; d0 = 16'h1000; d1 = 16'h2000;
    step();
    req = 3'b010;
    repeat (Hold - 1) step();
    req = 3'b011;
    step();
    n_chk++;
    if ({ack, owner, disp_data} !== {3'b010, 2'd1, 16'h2000})
      $display("FAIL boundary_grant: got ack=%b owner=%0d data=%h want 010/1/2000", ack, owner,
               disp_data);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
      step();
      n_chk++;
      if ({ack, disp_valid, owner, disp_data} !== {m_ack, m_valid, m_owner, m_disp} ||
          $countones(ack) > 1)
        $display("FAIL random[%0d]: got ack=%b valid=%b owner=%0d data=%h want %b/%b/%0d/%h",
                 i, ack, disp_valid, owner, disp_data, m_ack, m_valid, m_owner, m_disp);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_round_robin();
    test_tracking();
    test_regrant_same();
    test_reset_mid_show();
    test_boundary();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
